// File: rtl/fifo_pkg.sv
// Shared sizing for the BRAM-backed FWFT FIFO controller: default widths,
// depth derivation and the occupancy-counter width helper.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned AFULL_LVL_DEF = 12;

  // Number of BRAM entries addressed by an aw-bit pointer.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // The counter must hold 0..DEPTH inclusive, so one bit wider than a pointer.
  function automatic int unsigned cnt_w(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  localparam int unsigned DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping BRAM pointer. Exposes both the registered pointer and its
// incremented value so the read side can address the next head combinationally.
module fifo_ptr_ctr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_inc
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_inc_s;

  // Next pointer: advance by one on inc, wrapping through the natural width; clr wins.
  always_comb begin
    ptr_inc_s = ptr_q + ADDR_W'(inc);
    if (clr) begin
      ptr_d = {ADDR_W{1'b0}};
    end else begin
      ptr_d = ptr_inc_s;
    end
  end

  // Pointer register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {ADDR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr     = ptr_q;
  assign ptr_inc = ptr_inc_s;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external 16x8 simple
// dual-port BRAM (registered read, read-before-write on collision).
// The read address is steered one pop ahead so bram_rdata always holds the head.
module bram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned AFULL_LVL = AFULL_LVL_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  input  logic                flush,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_waddr,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic [ADDR_W-1:0]   bram_raddr,
  input  logic [DATA_W-1:0]   bram_rdata,
  output logic [ADDR_W:0]     count,
  output logic                almost_full
);

  localparam int unsigned CNT_W = cnt_w(ADDR_W);
  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              wr_d1_q;
  logic              wr_d1_d;

  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] wr_ptr_s;
  logic [ADDR_W-1:0] wr_ptr_inc_s;
  logic [ADDR_W-1:0] rd_ptr_s;
  logic [ADDR_W-1:0] rd_ptr_nxt_s;

  // Handshake flags come only from registers: no in_valid->in_ready or
  // out_ready->out_valid paths. The word written at the previous edge is
  // not yet visible on the read port, so it is excluded from out_valid.
  always_comb begin
    in_ready_s  = (count_q != DEPTH_C);
    out_valid_s = ((count_q - CNT_W'(wr_d1_q)) != {CNT_W{1'b0}});
    push_s      = in_valid  & in_ready_s  & ~flush;
    pop_s       = out_valid_s & out_ready & ~flush;
  end

  fifo_ptr_ctr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .inc     (push_s),
    .ptr     (wr_ptr_s),
    .ptr_inc (wr_ptr_inc_s)
  );

  fifo_ptr_ctr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .inc     (pop_s),
    .ptr     (rd_ptr_s),
    .ptr_inc (rd_ptr_nxt_s)
  );

  // Occupancy and write-delay tracking; flush discards any concurrent push/pop.
  always_comb begin
    count_d = count_q;
    wr_d1_d = push_s;
    if (flush) begin
      count_d = {CNT_W{1'b0}};
      wr_d1_d = 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy and write-delay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
      wr_d1_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_d1_q <= wr_d1_d;
    end
  end

  // Output mapping: BRAM ports, handshake flags and occupancy status.
  always_comb begin
    bram_we     = push_s;
    bram_waddr  = wr_ptr_s;
    bram_wdata  = in_data;
    bram_raddr  = rd_ptr_nxt_s;
    out_data    = bram_rdata;
    in_ready    = in_ready_s;
    out_valid   = out_valid_s;
    count       = count_q;
    almost_full = (count_q >= AFULL_C);
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural read-before-write BRAM.
module tb_bram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic       bram_we;
  logic [3:0] bram_waddr;
  logic [7:0] bram_wdata;
  logic [3:0] bram_raddr;
  logic [7:0] bram_rdata;
  logic [4:0] count;
  logic       almost_full;

  logic [7:0] mem [16];

  int n_tests;
  int n_fail;
  int pushed;
  int popped;

  bram_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .bram_we     (bram_we),
    .bram_waddr  (bram_waddr),
    .bram_wdata  (bram_wdata),
    .bram_raddr  (bram_raddr),
    .bram_rdata  (bram_rdata),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port BRAM: the read samples the array before this edge's write lands.
  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    bram_rdata <= mem[bram_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state
    #2;
    check_eq("rst_in_ready",  32'(in_ready),    32'd1);
    check_eq("rst_out_valid", 32'(out_valid),   32'd0);
    check_eq("rst_afull",     32'(almost_full), 32'd0);
    check_eq("rst_we",        32'(bram_we),     32'd0);
    check_eq("rst_raddr",     32'(bram_raddr),  32'd0);
    check_eq("rst_count",     32'(count),       32'd0);
    #10 rst_n = 1'b1;

    // Single push of 0xA5, first-word latency 2
    tick();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    check_eq("a5_we",    32'(bram_we),    32'd1);
    check_eq("a5_waddr", 32'(bram_waddr), 32'd0);
    check_eq("a5_wdata", 32'(bram_wdata), 32'hA5);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("a5_ov_e1", 32'(out_valid), 32'd0);
    check_eq("a5_cnt",   32'(count),     32'd1);
    tick();
    check_eq("a5_ov_e2", 32'(out_valid), 32'd1);
    check_eq("a5_data",  32'(out_data),  32'hA5);
    out_ready = 1'b1;
    #1;
    check_eq("a5_raddr_pop", 32'(bram_raddr), 32'd1);
    tick();
    out_ready = 1'b0;
    #1;
    check_eq("a5_ov_after", 32'(out_valid), 32'd0);
    check_eq("a5_cnt_after", 32'(count),    32'd0);

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      check_eq("fill_in_ready", 32'(in_ready), 32'd1);
      tick();
      check_eq("fill_count", 32'(count), 32'(i + 1));
      check_eq("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
    end
    in_data = 8'h55;
    #1;
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_we",       32'(bram_we),  32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("full_count_hold", 32'(count), 32'd16);

    // Drain with out_ready held
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("drain_valid", 32'(out_valid), 32'd1);
      check_eq("drain_data",  32'(out_data),  32'(i));
      tick();
    end
    out_ready = 1'b0;
    #1;
    check_eq("drain_ov_end",  32'(out_valid), 32'd0);
    check_eq("drain_cnt_end", 32'(count),     32'd0);

    // Streaming 40 words with in_valid/out_ready held; one word readable plus one in flight
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid  = (pushed < 40);
      in_data   = 8'(8'h80 + pushed);
      out_ready = 1'b1;
      #1;
      if (cyc >= 2 && cyc < 40) check_eq("stream_count", 32'(count), 32'd2);
      if (out_valid) begin
        check_eq("stream_data", 32'(out_data), 32'(8'h80 + popped));
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("stream_popped", 32'(popped), 32'd40);
    check_eq("stream_cnt_end", 32'(count), 32'd0);

    // Flush at count 7 with simultaneous push and pop request
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check_eq("pre_flush_cnt", 32'(count), 32'd7);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check_eq("flush_we", 32'(bram_we), 32'd0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("flush_cnt", 32'(count),     32'd0);
    check_eq("flush_ov",  32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    check_eq("flush_waddr", 32'(bram_waddr), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("flush_3c_valid", 32'(out_valid), 32'd1);
    check_eq("flush_3c_data",  32'(out_data),  32'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-burst at count 5
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + i);
      tick();
    end
    check_eq("prerst_cnt", 32'(count), 32'd5);
    in_data = 8'h25;
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_cnt",      32'(count),       32'd0);
    check_eq("arst_ov",       32'(out_valid),   32'd0);
    check_eq("arst_in_ready", 32'(in_ready),    32'd1);
    check_eq("arst_afull",    32'(almost_full), 32'd0);
    check_eq("arst_raddr",    32'(bram_raddr),  32'd0);
    in_valid = 1'b0;
    #1;
    check_eq("arst_we", 32'(bram_we), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_waddr", 32'(bram_waddr), 32'd0);
    check_eq("post_rst_raddr", 32'(bram_raddr), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_data",  32'(out_data),  32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
